uart_transmit_cfg: RTL
======================

Name: uart_transmit_cfg

Overview:
Parametrised next-generation UART transmitter with configurable data width, parity and stop-bit count.
- A small internal FIFO lets producers (MIDI/serial message builders) push bytes in bursts without waiting on busy.
- Frames are sent back-to-back with no idle gap while the FIFO holds data.
- Drives a single serial line, idle-high, LSB first.

Parameters:
- INPUT_CLOCK_FREQ, 100_000_000: clk_in frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s. CYCLE_PER_BIT = INPUT_CLOCK_FREQ/BAUD_RATE (integer divide, must be >= 2).
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, >= 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- data_byte_in  input  DATA_BITS  payload to enqueue.
- trigger_in  input  1  write strobe; one entry per cycle high.
- ready_out  output  1  FIFO not full; a write is accepted only when high.
- overflow_out  output  1  one-cycle pulse when trigger_in arrives while ready_out is low (data dropped).
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
- busy_out  output  1  high while a frame is on the line or FIFO is non-empty.
- tx_wire_out  output  1  serial line.

Behaviour:
- Reset (async assert, release on a clock edge):
  - tx_wire_out=1, busy_out=0, ready_out=1, overflow_out=0, fifo_count_out=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Reset mid-frame aborts the frame immediately and the line returns high. No partial-frame resume.
- FIFO:
  - Write occurs when trigger_in && ready_out. Pop is requested by the FSM.
  - Simultaneous write and pop when non-empty: fifo_count_out unchanged.
  - ready_out = (count != FIFO_DEPTH), registered. A write while full is rejected even if a pop happens that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop the head into shift register, compute parity, go to START with tx=0 and the bit counter cleared.
  - START: hold one bit period, then go to DATA.
  - DATA: shift out bit[0] first, DATA_BITS periods. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: one period.
    - Odd: tx = ~^data.
    - Even: tx = ^data.
  - STOP: tx=1 for STOP_BITS periods. On the final cycle of the last stop period:
    - FIFO non-empty: pop and go straight to START (tx=0 on the next cycle, zero idle gap).
    - Otherwise: go to IDLE.
- Timing:
  - The bit-period counter counts 0..CYCLE_PER_BIT-1; each line bit lasts exactly CYCLE_PER_BIT clk_in cycles.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CYCLE_PER_BIT cycles.
- Latency: with IDLE and an empty FIFO, a write accepted at edge N makes tx_wire_out low after edge N+2.
- busy_out = (state != IDLE) || (count != 0), registered with the same latency as the state.
- Outputs: tx_wire_out is a flop output with no combinational path from any input.
- Width rules:
  - Bit counter is sized for max(DATA_BITS, STOP_BITS).
  - Cycle counter is $clog2(CYCLE_PER_BIT) bits.
  - fifo_count_out is one bit wider than the pointers, to represent full.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - parity_t constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - Function cycles_per_bit(freq, baud).
- Sub-module uart_tx_fifo: synchronous FIFO with async reset. Parameters WIDTH and DEPTH; ports wr_en/din, rd_en/dout, count, full, empty. Show-ahead output, so the head is valid while not empty.
- The top holds the FSM, shift register and counters.

Test Plan:
All scenarios use INPUT_CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles/bit).
- 8N1, write 0xA5 once from idle -> tx low after 2 edges; line bits 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles. busy_out falls 100 cycles after start; tx idles high.
- PARITY=2, STOP_BITS=2, write 0x07 -> parity bit 1, two stop bits; frame 120 cycles. With PARITY=1 the parity bit is 0.
- Burst of 3 writes 0x01, 0x02, 0x03 on consecutive cycles -> fifo_count_out peaks at 3 (or 2 if a pop overlaps). Three frames back-to-back: the start bit of frame k+1 begins the cycle after frame k's last stop cycle.
- FIFO_DEPTH=4: 6 consecutive writes while the first frame is sending -> ready_out low once count=4; overflow_out pulses once per rejected write; only the accepted bytes appear on the line, in order.
- Assert rst_in asynchronously mid-DATA of 0x55 -> tx_wire_out=1 and busy_out=0 without waiting for a clock edge; FIFO empty; a new write after release sends a clean full frame.
- DATA_BITS=5, write 0x1F (upper bits ignored) -> exactly 5 data bits of 1 are sent, then stop; frame 70 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    // Clock cycles spent on each line bit (integer divide).
    function automatic int cycles_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO with asynchronous reset; head is valid while not empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_in) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_transmit_cfg.sv
// Configurable UART transmitter: FIFO-fed frame FSM with parity and 1/2 stop bits.
module uart_transmit_cfg
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DATA_BITS-1:0]          data_byte_in,
    input  logic                          trigger_in,
    output logic                          ready_out,
    output logic                          overflow_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          busy_out,
    output logic                          tx_wire_out
);

    localparam int CPB  = cycles_per_bit(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != int'(PAR_NONE));
    localparam bit            ODD_PAR   = (PARITY == int'(PAR_ODD));

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q;

    logic                 fifo_full, fifo_empty, pop, cyc_end;
    logic [DATA_BITS-1:0] fifo_head;

    assign ready_out    = !fifo_full;
    assign overflow_out = overflow_q;
    assign busy_out     = busy_q;
    assign tx_wire_out  = tx_q;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .wr_en  (trigger_in && ready_out),
        .din    (data_byte_in),
        .rd_en  (pop),
        .dout   (fifo_head),
        .count  (fifo_count_out),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign cyc_end = (cyc_q == CYC_LAST);

    // Frame sequencing: next state, counters, shift register and FIFO pop.
    // The line and busy flops are driven from the current state, so they
    // trail the FSM by one cycle; that gives the two-edge write-to-start latency.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        busy_d  = (state_q != IDLE) || !fifo_empty;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    par_d   = ODD_PAR ? ~^fifo_head : ^fifo_head;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (cyc_end) begin
                    cyc_d   = '0;
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (cyc_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? uart_pkg::PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            uart_pkg::PARITY: begin
                tx_d = par_q;
                if (cyc_end) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (cyc_end) begin
                    cyc_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            par_d   = ODD_PAR ? ~^fifo_head : ^fifo_head;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= trigger_in && fifo_full;
        end
    end

endmodule
